// File: rtl/wr_logic.sv
// Write-domain pointer, full and overflow logic for an asynchronous FIFO.
// Optional fill level / almost_full reporting is compiled in when WR_LEVEL_EN is defined.
module wr_logic #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic                  ovf_clr,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic                  wr_ce,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  almost_full
);

  localparam int AW = ADDR_WIDTH;

  // Full means the write Gray pointer equals the read Gray pointer with its top two bits
  // inverted; for AW=1 this mask covers both pointer bits.
  localparam logic [AW:0] FULL_MASK = (AW+1)'(3) << (AW - 1);

  logic [AW:0] wbin_q, wbin_d;
  logic [AW:0] wgray_q, wgray_d;
  logic        full_q, full_d;
  logic        overflow_q, overflow_d;
  logic        wr_ce_c;

  always_comb begin
    wr_ce_c    = wr_en & ~full_q;
    wbin_d     = wbin_q + {{AW{1'b0}}, wr_ce_c};
    wgray_d    = wbin_d ^ (wbin_d >> 1);
    full_d     = (wgray_d == (wq2_rptr ^ FULL_MASK));
    overflow_d = (wr_en & full_q) | (overflow_q & ~ovf_clr);
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef WR_LEVEL_EN
  localparam logic [AW:0] AF_LIM = (AW+1)'(AF_THRESH);

  logic [AW:0] rbin_s;
  logic [AW:0] level_q, level_d;
  logic        almost_full_q, almost_full_d;

  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= AW; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
    level_d       = wbin_d - rbin_s;
    almost_full_d = (level_d >= AF_LIM);
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      level_q       <= level_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign wr_level    = level_q;
  assign almost_full = almost_full_q;
`else
  assign wr_level    = '0;
  assign almost_full = 1'b0;
`endif

  assign wr_ptr      = wbin_q[AW-1:0];
  assign wr_ce       = wr_ce_c;
  assign wr_ptr_gray = wgray_q;
  assign full        = full_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_wr_logic.sv
// Directed bench for wr_logic (ADDR_WIDTH=4, AF_THRESH=12); level expectations follow WR_LEVEL_EN.
module tb_wr_logic;

  logic       wr_clk;
  logic       wr_rst_n;
  logic       wr_en;
  logic [4:0] wq2_rptr;
  logic       ovf_clr;
  logic [3:0] wr_ptr;
  logic       wr_ce;
  logic [4:0] wr_ptr_gray;
  logic       full;
  logic       overflow;
  logic [4:0] wr_level;
  logic       almost_full;

  int checks = 0;
  int errors = 0;

  wr_logic #(.ADDR_WIDTH(4), .AF_THRESH(12)) dut (
    .wr_clk      (wr_clk),
    .wr_rst_n    (wr_rst_n),
    .wr_en       (wr_en),
    .wq2_rptr    (wq2_rptr),
    .ovf_clr     (ovf_clr),
    .wr_ptr      (wr_ptr),
    .wr_ce       (wr_ce),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
    .overflow    (overflow),
    .wr_level    (wr_level),
    .almost_full (almost_full)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  function automatic logic [4:0] bin2gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] exp_level(input logic [4:0] lvl);
`ifdef WR_LEVEL_EN
    return lvl;
`else
    return 5'd0;
`endif
  endfunction

  function automatic logic exp_af(input logic af);
`ifdef WR_LEVEL_EN
    return af;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic apply_reset();
    wr_en    = 1'b0;
    ovf_clr  = 1'b0;
    wq2_rptr = 5'd0;
    wr_rst_n = 1'b0;
    #2;
    wr_rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    wr_en = 1'b0; ovf_clr = 1'b0; wq2_rptr = 5'd0; wr_rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({wr_ptr, wr_ptr_gray, full, overflow, wr_level, almost_full} !== 17'd0) begin
      errors++;
      $display("FAIL reset_state: got ptr=%0d gray=%b full=%b ovf=%b lvl=%0d af=%b, want all 0",
               wr_ptr, wr_ptr_gray, full, overflow, wr_level, almost_full);
    end
    wr_rst_n = 1'b1;
    wr_en = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (wr_ptr !== 4'd3 || wr_ptr_gray !== 5'b00010) begin
      errors++;
      $display("FAIL burst_before_reset: got ptr=%0d gray=%b, want 3 00010", wr_ptr, wr_ptr_gray);
    end
    #2;
    wr_rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_ptr, wr_ptr_gray, full, overflow, wr_level, almost_full} !== 17'd0) begin
      errors++;
      $display("FAIL async_reset: got ptr=%0d gray=%b full=%b ovf=%b lvl=%0d af=%b, want all 0",
               wr_ptr, wr_ptr_gray, full, overflow, wr_level, almost_full);
    end
    #2;
    wr_rst_n = 1'b1;
    #1;
    checks++;
    if (wr_ptr !== 4'd0 || wr_ce !== 1'b1) begin
      errors++;
      $display("FAIL first_write_addr: got ptr=%0d ce=%b, want 0 1", wr_ptr, wr_ce);
    end
    tick();
    checks++;
    if (wr_ptr !== 4'd1 || wr_ptr_gray !== 5'b00001) begin
      errors++;
      $display("FAIL first_write_adv: got ptr=%0d gray=%b, want 1 00001", wr_ptr, wr_ptr_gray);
    end
  endtask

  task automatic test_fill();
    apply_reset();
    wr_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      #1;
      checks++;
      if (wr_ptr !== 4'(k - 1) || wr_ce !== 1'b1) begin
        errors++;
        $display("FAIL fill_addr[%0d]: got ptr=%0d ce=%b, want %0d 1", k, wr_ptr, wr_ce, k - 1);
      end
      tick();
      checks++;
      if (full !== (k == 16) || wr_level !== exp_level(5'(k)) || almost_full !== exp_af(k >= 12)
          || overflow !== 1'b0) begin
        errors++;
        $display("FAIL fill_flags[%0d]: got full=%b lvl=%0d af=%b ovf=%b, want %b %0d %b 0",
                 k, full, wr_level, almost_full, overflow, (k == 16), exp_level(5'(k)), exp_af(k >= 12));
      end
    end
    #1;
    checks++;
    if (wr_ce !== 1'b0 || wr_ptr !== 4'd0) begin
      errors++;
      $display("FAIL fill_blocked: got ce=%b ptr=%0d, want 0 0", wr_ce, wr_ptr);
    end
    tick();
    checks++;
    if (overflow !== 1'b1 || full !== 1'b1 || wr_ptr !== 4'd0 || wr_ptr_gray !== 5'b11000) begin
      errors++;
      $display("FAIL fill_overflow: got ovf=%b full=%b ptr=%0d gray=%b, want 1 1 0 11000",
               overflow, full, wr_ptr, wr_ptr_gray);
    end
  endtask

  task automatic test_overflow_clear();
    ovf_clr = 1'b1;
    wr_en   = 1'b1;
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: got %b, want 1", overflow);
    end
    wr_en = 1'b0;
    tick();
    checks++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%b full=%b, want 0 1", overflow, full);
    end
    ovf_clr = 1'b0;
    tick();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_stays_clear: got %b, want 0", overflow);
    end
  endtask

  task automatic test_drain_release();
    wq2_rptr = 5'b00110;
    tick();
    checks++;
    if (full !== 1'b0 || wr_level !== exp_level(5'd12) || almost_full !== exp_af(1'b1) || wr_ptr !== 4'd0) begin
      errors++;
      $display("FAIL drain_4: got full=%b lvl=%0d af=%b ptr=%0d, want 0 %0d %b 0",
               full, wr_level, almost_full, wr_ptr, exp_level(5'd12), exp_af(1'b1));
    end
    wq2_rptr = bin2gray(5'd5);
    tick();
    checks++;
    if (full !== 1'b0 || wr_level !== exp_level(5'd11) || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL drain_5: got full=%b lvl=%0d af=%b, want 0 %0d 0",
               full, wr_level, almost_full, exp_level(5'd11));
    end
  endtask

  task automatic test_wrap();
    logic [4:0] mw;
    logic [4:0] prev;
    logic [4:0] rb;
    apply_reset();
    mw = 5'd0;
    prev = 5'd0;
    for (int n = 1; n <= 40; n++) begin
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      mw = mw + 5'd1;
      checks++;
      if (wr_ptr_gray !== bin2gray(mw) || $countones(wr_ptr_gray ^ prev) != 1 || full !== 1'b0) begin
        errors++;
        $display("FAIL wrap_write[%0d]: got gray=%b full=%b prev=%b, want %b 0",
                 n, wr_ptr_gray, full, prev, bin2gray(mw));
      end
      if (n == 32) begin
        checks++;
        if (prev !== 5'b10000 || wr_ptr_gray !== 5'b00000 || wr_ptr !== 4'd0) begin
          errors++;
          $display("FAIL wrap_rollover: got prev=%b gray=%b ptr=%0d, want 10000 00000 0",
                   prev, wr_ptr_gray, wr_ptr);
        end
      end
      prev = wr_ptr_gray;
      rb = (n >= 2) ? (mw - 5'd2) : 5'd0;
      wq2_rptr = bin2gray(rb);
      tick();
      checks++;
      if (wr_ptr_gray !== prev || full !== 1'b0 || wr_level !== exp_level(mw - rb)) begin
        errors++;
        $display("FAIL wrap_idle[%0d]: got gray=%b full=%b lvl=%0d, want %b 0 %0d",
                 n, wr_ptr_gray, full, wr_level, prev, exp_level(mw - rb));
      end
    end
  endtask

  initial begin
    wr_rst_n = 1'b0;
    wr_en    = 1'b0;
    ovf_clr  = 1'b0;
    wq2_rptr = 5'd0;
    test_reset();
    test_fill();
    test_overflow_clear();
    test_drain_release();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
